// File: rtl/i2c_reg_master.sv
// Byte-oriented I2C master for single-register write and read transactions.
// Drives open-drain SCL/SDA enables from a quarter-period bit-slot sequencer.
module i2c_reg_master #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] addr,
    input  logic [7:0] sub_addr,
    input  logic [7:0] data_wr,
    output logic [7:0] data_rd,
    output logic       busy,
    output logic       ack_err,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in,
    output logic [3:0] dbg_state
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR_W, ACK_A, SUB, ACK_S, WDATA, ACK_D,
        RSTART, ADDR_R, ACK_R, RDATA, MNACK, STOP
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_qcnt;
    logic [1:0]    r_q;
    logic [1:0]    w_q_nxt;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    r_addr;
    logic [7:0]    r_sub;
    logic [7:0]    r_wdat;
    logic [7:0]    r_shift;
    logic          r_samp;
    logic          r_err;
    logic          w_tick;
    logic          w_slot_end;
    logic          w_last;
    logic [7:0]    w_txb;
    logic          w_scl_nxt;
    logic          w_sda_nxt;

    function automatic logic f_is_byte(input state_t s);
        return (s == ADDR_W) || (s == SUB) || (s == WDATA) ||
               (s == ADDR_R) || (s == RDATA);
    endfunction

    assign dbg_state  = r_state;
    assign w_tick     = (r_qcnt == CW'(CLK_DIV - 1));
    assign w_slot_end = (r_state != IDLE) && w_tick && (r_q == 2'd3);

    // ena is a one-cycle request, accepted only in IDLE; it is ignored otherwise.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_bit_nxt   = r_bit;
        w_last      = (r_bit == 3'd0);
        if (r_state == IDLE) begin
            if (ena) begin
                w_state_nxt = START;
                w_q_nxt     = 2'd0;
                w_bit_nxt   = 3'd7;
            end
        end else if (w_tick) begin
            w_q_nxt = r_q + 2'd1;
            if (r_q == 2'd3) begin
                w_bit_nxt = (f_is_byte(r_state) && !w_last) ? r_bit - 3'd1 : 3'd7;
                case (r_state)
                    START:   w_state_nxt = ADDR_W;
                    ADDR_W:  if (w_last) w_state_nxt = ACK_A;
                    ACK_A:   w_state_nxt = r_samp ? STOP : SUB;
                    SUB:     if (w_last) w_state_nxt = ACK_S;
                    ACK_S:   w_state_nxt = r_samp ? STOP : (r_addr[0] ? RSTART : WDATA);
                    WDATA:   if (w_last) w_state_nxt = ACK_D;
                    ACK_D:   w_state_nxt = STOP;
                    RSTART:  w_state_nxt = ADDR_R;
                    ADDR_R:  if (w_last) w_state_nxt = ACK_R;
                    ACK_R:   w_state_nxt = r_samp ? STOP : RDATA;
                    RDATA:   if (w_last) w_state_nxt = MNACK;
                    MNACK:   w_state_nxt = STOP;
                    default: w_state_nxt = IDLE;
                endcase
            end
        end
    end

    // Pin enables are a function of the upcoming slot position, so they only move on a quarter boundary.
    always_comb begin
        w_scl_nxt = 1'b0;
        w_sda_nxt = 1'b0;
        case (w_state_nxt)
            ADDR_W:  w_txb = {r_addr[7:1], 1'b0};
            ADDR_R:  w_txb = {r_addr[7:1], 1'b1};
            SUB:     w_txb = r_sub;
            WDATA:   w_txb = r_wdat;
            default: w_txb = 8'hFF;
        endcase
        case (w_state_nxt)
            IDLE: begin
                w_scl_nxt = 1'b0;
                w_sda_nxt = 1'b0;
            end
            START: begin
                w_scl_nxt = 1'b0;
                w_sda_nxt = w_q_nxt[1];
            end
            RSTART: begin
                w_scl_nxt = (w_q_nxt == 2'd0);
                w_sda_nxt = w_q_nxt[1];
            end
            STOP: begin
                w_scl_nxt = (w_q_nxt == 2'd0);
                w_sda_nxt = ~w_q_nxt[1];
            end
            ADDR_W, SUB, WDATA, ADDR_R: begin
                w_scl_nxt = ~w_q_nxt[1];
                w_sda_nxt = ~w_txb[w_bit_nxt];
            end
            default: begin
                w_scl_nxt = ~w_q_nxt[1];
                w_sda_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_qcnt  <= '0;
            r_q     <= 2'd0;
            r_bit   <= 3'd7;
            r_addr  <= 8'h00;
            r_sub   <= 8'h00;
            r_wdat  <= 8'h00;
            r_shift <= 8'h00;
            r_samp  <= 1'b0;
            r_err   <= 1'b0;
            data_rd <= 8'h00;
            busy    <= 1'b0;
            ack_err <= 1'b0;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_bit   <= w_bit_nxt;
            scl_oe  <= w_scl_nxt;
            sda_oe  <= w_sda_nxt;
            if (r_state == IDLE || w_tick) begin
                r_qcnt <= '0;
            end else begin
                r_qcnt <= r_qcnt + 1'b1;
            end
            if (r_state == IDLE && ena) begin
                r_addr  <= addr;
                r_sub   <= sub_addr;
                r_wdat  <= data_wr;
                r_err   <= 1'b0;
                ack_err <= 1'b0;
                busy    <= 1'b1;
            end
            // SDA is sampled on the first edge of Q3, in the middle of SCL high.
            if (r_state != IDLE && w_tick && r_q == 2'd2) begin
                r_samp <= sda_in;
                if (r_state == RDATA) begin
                    r_shift <= {r_shift[6:0], sda_in};
                end
            end
            if (w_slot_end) begin
                if ((r_state == ACK_A || r_state == ACK_S ||
                     r_state == ACK_D || r_state == ACK_R) && r_samp) begin
                    r_err <= 1'b1;
                end
                if (r_state == RDATA && r_bit == 3'd0) begin
                    data_rd <= r_shift;
                end
                if (r_state == STOP) begin
                    busy    <= 1'b0;
                    ack_err <= r_err;
                end
            end
        end
    end

endmodule

// File: doc/i2c_reg_master.md
# i2c_reg_master

Byte-oriented I2C master that executes single-register write and read transactions for the altimeter controller. It accepts a one-cycle request (device address, register sub-address, write byte), generates open-drain SCL/SDA waveforms to the pressure/temperature sensor, and returns the read byte, a busy flag and an acknowledge-error flag. It sits directly downstream of the altimeter controller and is the only block that touches the I2C pins.

## Interface
- CLK_DIV, 125, `clk` cycles per SCL quarter-period. Default gives 100 kHz SCL at 50 MHz. Must be ≥ 2.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- ena  in  1  transaction request; sampled only in IDLE.
- addr  in  8  [7:1] 7-bit slave address; [0] 1 = read, 0 = write.
- sub_addr  in  8  register address sent after the address byte.
- data_wr  in  8  byte written in a write transaction.
- data_rd  out  8  byte received by the last successful read.
- busy  out  1  high while a transaction is in progress.
- ack_err  out  1  high if the slave NACKed any address, sub-address or data byte of the last transaction.
- scl_oe  out  1  1 = drive SCL low; 0 = release SCL (pulled high externally).
- sda_oe  out  1  1 = drive SDA low; 0 = release SDA.
- sda_in  in  1  sampled SDA pin level. The pin is assumed already synchronised to `clk` externally.

## Operation
- **Reset values:** data_rd = 0x00, busy = 0, ack_err = 0, scl_oe = 0, sda_oe = 0. The FSM is in IDLE and the quarter counter is 0. Reset asserted mid-transaction releases both lines immediately and abandons the transfer; no STOP is generated.
- **Request acceptance:**
  - On a rising edge in IDLE with ena = 1, latch addr, sub_addr and data_wr, and clear ack_err.
  - busy goes to 1 on that same edge.
  - ena while busy is ignored.
  - If ena is held high, the next transaction is accepted on the first edge after returning to IDLE, so busy is low for exactly one cycle between transactions.
- **FSM states:** IDLE, START, ADDR_W, ACK_A, SUB, ACK_S, WDATA, ACK_D, RSTART, ADDR_R, ACK_R, RDATA, MNACK, STOP.
- **Write sequence:** START → ADDR_W → ACK_A → SUB → ACK_S → WDATA → ACK_D → STOP.
- **Read sequence:** START → ADDR_W → ACK_A → SUB → ACK_S → RSTART → ADDR_R → ACK_R → RDATA → MNACK → STOP.
- **Address bytes:** ADDR_W sends {addr[7:1], 0}. ADDR_R sends {addr[7:1], 1}.
- **Byte states:** each byte state lasts 8 bits, MSB first.
- **Bit-slot timing:** every bit slot is 4 quarters (Q0–Q3), each CLK_DIV cycles long.
  - Q0: SCL low; SDA updated at the start of Q0.
  - Q1: SCL low.
  - Q2: SCL high.
  - Q3: SCL high.
  - sda_in is sampled on the first edge of Q3.
- **Master-transmitted bits:** sda_oe = ~bit.
- **ACK slots:** SDA is released. Sampled 1 = NACK → set ack_err and go to STOP, skipping the remaining states. data_rd is not updated on an error.
- **RDATA:** SDA is released; shift sda_in in MSB first. data_rd is loaded on exit from RDATA.
- **MNACK:** the master releases SDA (NACK) for the whole slot.
- **START (from idle-high bus):**

  | Quarter | SCL | SDA |
  |---|---|---|
  | Q0 | released | released |
  | Q1 | released | released |
  | Q2 | released | low |
  | Q3 | released | low |

- **RSTART:**

  | Quarter | SCL | SDA |
  |---|---|---|
  | Q0 | low | released |
  | Q1 | released | released |
  | Q2 | released | low |
  | Q3 | released | low |

- **STOP:**

  | Quarter | SCL | SDA |
  |---|---|---|
  | Q0 | low | low |
  | Q1 | released | low |
  | Q2 | released | released |
  | Q3 | released | released |

- **Exit from STOP:** after STOP, return to IDLE and clear busy.
- No clock stretching, no multi-master arbitration. The SCL level is not monitored.

## Timing
- One accepted request leads to a fixed-length transaction. The number of quarters depends on the outcome:

  | Outcome | Breakdown | Quarters |
  |---|---|---|
  | Successful write | 4 + 3×36 + 4 | 116 |
  | Successful read | 4 + 2×36 + 4 + 36 + 36 + 4 | 156 |
  | NACK on address | 4 + 36 + 4 | 44 |
  | NACK on sub-address | 4 + 72 + 4 | 80 |

- busy stays high for exactly quarters × CLK_DIV cycles, starting the edge after acceptance.
- data_rd and ack_err become valid on the same edge that busy falls. Both are held until the next acceptance: ack_err is cleared at acceptance, and data_rd changes only on the next successful read.
- Within a quarter, output changes occur only on the first edge of the quarter.

## Test plan
- **Write:** CLK_DIV = 4, slave model ACKs all bytes, addr = 0xC0, sub_addr = 0x26, data_wr = 0xB8, ena pulsed 1 cycle → expected:
  - SDA bytes 0xC0, 0x26, 0xB8 observed.
  - busy high exactly 464 cycles, ack_err = 0.
  - Bus ends with both lines released.
- **Read:** addr = 0xC1, sub_addr = 0x01, slave returns 0x5A → expected:
  - Bytes 0xC0, 0x26-style sub_addr 0x01, repeated START, 0xC1 observed.
  - Master NACK after the data byte.
  - data_rd = 0x5A when busy falls; busy high 624 cycles.
- **Address NACK:** slave NACKs the address byte of a write → expected:
  - ack_err = 1 and STOP issued after 44 quarters (176 cycles).
  - No sub_addr bits on SDA; data_rd unchanged.
- **Back-to-back:** ena held high through two reads → expected:
  - busy low exactly 1 cycle between transactions.
  - ack_err of the second transaction cleared at its acceptance.
- **Reset mid-transaction:** rst driven low during SUB, asynchronously to clk → expected:
  - scl_oe = sda_oe = busy = ack_err = 0 and data_rd = 0x00 immediately.
  - A new write completes normally after rst is released.
- **ena while busy:** pulse ena mid-transaction with different addr → expected: it is ignored, and the SDA byte sequence matches the original request only.
